// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 serial receiver with a first-word-fall-through byte FIFO.
//               The rx line is double-flopped, deframed by a one-hot FSM that
//               samples mid-bit, and good bytes are pushed into the FIFO. The
//               FIFO head, the not-empty flag and the pop strobe form the
//               consumer-side handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i            system clock, rising-edge active
//   rst_ni           asynchronous active-low reset
//   rx_i             asynchronous serial line, idles high
//   data_out_o       FIFO head byte, 8'h00 when empty
//   data_present_o   FIFO not empty
//   data_read_i      pop strobe from the consumer
//   fill_count_o     bytes held, 0 .. 2**FIFO_AW
//   framing_error_o  one-cycle pulse on a bad stop bit
//   overrun_error_o  sticky: a byte was dropped because the FIFO was full
//   clear_errors_i   synchronous clear of overrun_error_o
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rx_i,
    output logic [7:0]         data_out_o,
    output logic               data_present_o,
    input  logic               data_read_i,
    output logic [FIFO_AW:0]   fill_count_o,
    output logic               framing_error_o,
    output logic               overrun_error_o,
    input  logic               clear_errors_i
);

    localparam int                 DEPTH      = 1 << FIFO_AW;
    localparam int                 CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [FIFO_AW:0]   FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer: both flops reset to the idle (high) level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             framing_q;

    logic w_bit_tick;
    logic w_push;

    assign w_bit_tick = (cnt_q == BIT_LAST);
    // The push is combinational so the FIFO updates on the stop-sample edge.
    assign w_push     = (state_q == ST_STOP) && w_bit_tick && rx_s_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            framing_q <= 1'b0;
        end else begin
            framing_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_tick) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_tick) begin
                        cnt_q     <= '0;
                        state_q   <= ST_IDLE;
                        framing_q <= ~rx_s_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign framing_error_o = framing_q;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic               overrun_q, overrun_d;

    logic w_pop;
    logic w_full;
    logic w_write;
    logic w_overrun_set;

    assign data_present_o = (count_q != '0);
    assign w_full         = (count_q == FULL_COUNT);
    assign w_pop          = data_read_i && data_present_o;
    // A push into a full FIFO still lands if a pop frees a slot this cycle.
    assign w_write        = w_push && (!w_full || w_pop);
    assign w_overrun_set  = w_push && w_full && !w_pop;

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({w_write, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new overrun outranks a clear in the same cycle.
        if (w_overrun_set) begin
            overrun_d = 1'b1;
        end else if (clear_errors_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: unread entries are masked by data_present_o.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign data_out_o      = data_present_o ? mem_q[rd_ptr_q] : 8'h00;
    assign fill_count_o    = count_q;
    assign overrun_error_o = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. A queue-based model
//               predicts FIFO contents, flags and the framing pulse; a
//               negedge process compares the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    // Line falls after edge k: two synchronizer flops plus one cycle for the
    // idle state to register it, half a bit to mid start, nine bit times to
    // mid stop bit.
    localparam int LAT   = 3 + CPB / 2 + 9 * CPB;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx    = 1'b1;
    logic          rd    = 1'b0;
    logic          clr   = 1'b0;
    logic [7:0]    dout;
    logic          present;
    logic [AW:0]   fill;
    logic          fe;
    logic          ovr;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .rx_i            (rx),
        .data_out_o      (dout),
        .data_present_o  (present),
        .data_read_i     (rd),
        .fill_count_o    (fill),
        .framing_error_o (fe),
        .overrun_error_o (ovr),
        .clear_errors_i  (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [7:0] b;
        bit         good;
    } sched_t;

    sched_t     sched[$];
    logic [7:0] mq[$];
    bit         m_ovr      = 1'b0;
    bit         m_fe       = 1'b0;
    int         edge_no    = 0;
    int         checks     = 0;
    int         failures   = 0;
    int         fe_pulses  = 0;
    int         rise_edge  = -1;
    bit         prev_pres  = 1'b0;
    int         last_k     = 0;
    bit         rand_done  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    // Reference model: updated on every rising edge from the frame schedule.
    always @(posedge clk) begin
        sched_t     s;
        bit         push;
        bit         pop;
        bit         full;
        logic [7:0] pb;
        edge_no++;
        m_fe = 1'b0;
        if (!rst_n) begin
            mq.delete();
            sched.delete();
            m_ovr = 1'b0;
        end else begin
            push = 1'b0;
            pb   = 8'h00;
            if (sched.size() > 0 && sched[0].e == edge_no) begin
                s = sched.pop_front();
                if (s.good) push = 1'b1;
                else        m_fe = 1'b1;
                pb = s.b;
            end
            pop  = rd && (mq.size() > 0);
            full = (mq.size() == DEPTH);
            if (push && full && !pop) m_ovr = 1'b1;
            else if (clr)             m_ovr = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push && (!full || pop)) mq.push_back(pb);
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] exp_head;
        if (!rst_n) begin
            chk("rst_fill",    32'(fill),    32'd0);
            chk("rst_present", 32'(present), 32'd0);
            chk("rst_data",    32'(dout),    32'd0);
            chk("rst_framing", 32'(fe),      32'd0);
            chk("rst_overrun", 32'(ovr),     32'd0);
        end else begin
            exp_head = 8'h00;
            if (mq.size() > 0) exp_head = mq[0];
            chk("fill",     32'(fill),    32'(mq.size()));
            chk("present",  32'(present), 32'(mq.size() != 0));
            chk("data_out", 32'(dout),    32'(exp_head));
            chk("overrun",  32'(ovr),     32'(m_ovr));
            chk("framing",  32'(fe),      32'(m_fe));
        end
        if (fe) fe_pulses++;
        if (present && !prev_pres) rise_edge = edge_no;
        prev_pres = present;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Must be called 1 time unit after a rising edge; returns likewise, so
    // consecutive calls produce back-to-back frames.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] bits;
        bits   = {stop_ok, b, 1'b0};
        last_k = edge_no;
        sched.push_back('{last_k + LAT, b, stop_ok});
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            idle(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic pop1();
        rd = 1'b1;
        idle(1);
        rd = 1'b0;
    endtask

    initial begin
        int f0;
        int k;

        rst_n = 1'b0;
        idle(4);
        rst_n = 1'b1;
        idle(4);

        // Single byte
        rise_edge = -1;
        send_frame(8'hA5, 1'b1);
        idle(2);
        chk("single_latency", 32'(rise_edge - last_k), 32'd155);
        chk("single_data",    32'(dout),    32'hA5);
        chk("single_fill",    32'(fill),    32'd1);
        pop1();
        chk("single_pop_present", 32'(present), 32'd0);
        chk("single_pop_data",    32'(dout),    32'h00);

        // False start
        f0 = fe_pulses;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        chk("false_start_fill", 32'(fill), 32'd0);
        chk("false_start_fe",   32'(fe_pulses - f0), 32'd0);
        send_frame(8'h3C, 1'b1);
        idle(2);
        chk("after_false_data", 32'(dout), 32'h3C);
        pop1();

        // Framing error
        f0 = fe_pulses;
        send_frame(8'h55, 1'b0);
        idle(20);
        chk("framing_once", 32'(fe_pulses - f0), 32'd1);
        chk("framing_fill", 32'(fill), 32'd0);
        send_frame(8'h12, 1'b1);
        idle(2);
        chk("after_framing_data", 32'(dout), 32'h12);
        pop1();

        // Overrun
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        idle(2);
        chk("overrun_fill", 32'(fill), 32'd16);
        chk("overrun_flag", 32'(ovr),  32'd1);
        rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("overrun_drain", 32'(dout), 32'(i));
            idle(1);
        end
        rd = 1'b0;
        chk("overrun_drained", 32'(fill), 32'd0);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("overrun_cleared", 32'(ovr), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        k = edge_no;
        fork
            send_frame(8'h10, 1'b1);
            begin
                while (edge_no != k + LAT - 1) idle(1);
                rd = 1'b1;
                idle(1);
                rd = 1'b0;
            end
        join
        idle(2);
        chk("fullpp_fill",    32'(fill), 32'd16);
        chk("fullpp_overrun", 32'(ovr),  32'd0);
        rd = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("fullpp_drain", 32'(dout), 32'(i));
            idle(1);
        end
        rd = 1'b0;

        // Reset mid-frame during data bit 4 of 0xFF
        idle(2);
        rx = 1'b0;
        idle(CPB);
        rx = 1'b1;
        idle(CPB * 4 + CPB / 2);
        rst_n = 1'b0;
        idle(3);
        chk("midrst_fill",    32'(fill),    32'd0);
        chk("midrst_present", 32'(present), 32'd0);
        chk("midrst_data",    32'(dout),    32'h00);
        rst_n = 1'b1;
        idle(CPB * 12);
        chk("midrst_nopush", 32'(fill), 32'd0);
        send_frame(8'h81, 1'b1);
        idle(2);
        chk("after_rst_data", 32'(dout), 32'h81);
        pop1();

        // Randomized traffic
        fork
            begin
                while (!rand_done) begin
                    rd  = ($urandom_range(0, 3) == 0);
                    clr = ($urandom_range(0, 63) == 0);
                    idle(1);
                end
                rd  = 1'b0;
                clr = 1'b0;
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [7:0] b;
                    bit         good;
                    int         gap;
                    b    = 8'($urandom);
                    good = ($urandom_range(0, 7) != 0);
                    send_frame(b, good);
                    // A bad stop bit needs idle time to resynchronise.
                    gap = good ? int'($urandom_range(0, 2)) : 20 + int'($urandom_range(0, 8));
                    if (gap > 0) idle(gap);
                end
                rand_done = 1'b1;
            end
        join
        rd = 1'b1;
        idle(40);
        rd = 1'b0;
        idle(5);
        chk("final_fill", 32'(fill), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
